// File: rtl/spectrum_peak_finder_pkg.sv
// rtl/spectrum_peak_finder_pkg.sv - shared state encodings and result-field offsets
//
// Purpose: types and helpers shared by spectrum_peak_finder and its consumers.
//   pf_state_e           : frame-tracking states (ST_IDLE, ST_ACCUM)
//   res_idx_lsb/msb(..)  : bit positions of the bin-index field inside tdata_m
//                          ({index, peak}, peak in the low DW bits)
package spectrum_peak_finder_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } pf_state_e;

    function automatic int res_idx_lsb(input int dw);
        return dw;
    endfunction

    function automatic int res_idx_msb(input int iw, input int dw);
        return iw + dw - 1;
    endfunction

endpackage

// File: rtl/spectrum_peak_finder_peak_cmp.sv
// rtl/spectrum_peak_finder_peak_cmp.sv - clamp, strict compare and running-peak registers
//
// Purpose: holds the running peak magnitude and its bin index for the frame in progress.
// Ports:
//   clk, reset_n         : clock, asynchronous active-low reset
//   i_update             : an in-frame beat was accepted this cycle; commit o_next_*
//   i_load               : the beat starts a frame; peak restarts from this sample at bin 0
//   i_sample             : signed magnitude sample
//   i_index              : bin position of the sample (ignored on i_load)
//   o_next_peak/o_next_idx : peak/index including the current sample (combinational)
module spectrum_peak_finder_peak_cmp #(
    parameter int DW = 16,
    parameter int IW = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_update,
    input  logic                 i_load,
    input  logic signed [DW-1:0] i_sample,
    input  logic        [IW-1:0] i_index,
    output logic        [DW-1:0] o_next_peak,
    output logic        [IW-1:0] o_next_idx
);

    logic [DW-1:0] r_peak;
    logic [IW-1:0] r_peak_idx;
    logic [DW-1:0] w_mag;
    logic          w_gt;

    // Negative magnitudes carry no energy; clamping keeps the compare unsigned.
    assign w_mag = i_sample[DW-1] ? '0 : i_sample;

    // Strict greater-than: the lowest bin keeps the peak on a tie.
    assign w_gt = (w_mag > r_peak);

    always_comb begin
        o_next_peak = r_peak;
        o_next_idx  = r_peak_idx;
        if (i_load) begin
            o_next_peak = w_mag;
            o_next_idx  = '0;
        end else if (w_gt) begin
            o_next_peak = w_mag;
            o_next_idx  = i_index;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_peak     <= '0;
            r_peak_idx <= '0;
        end else if (i_update) begin
            r_peak     <= o_next_peak;
            r_peak_idx <= o_next_idx;
        end
    end

endmodule

// File: rtl/spectrum_peak_finder.sv
// rtl/spectrum_peak_finder.sv - per-frame peak magnitude and bin index finder
//
// Purpose: consumes a magnitude stream framed by tuser_s (first bin) / tlast_s (last bin)
// and emits one {peak_idx, peak} beat per completed frame.
// Optional feature macro: PEAK_THRESHOLD_EN adds input thresh; frames whose clamped
// peak is below thresh produce no result beat.
// Ports:
//   clk, reset_n, ce     : clock, asynchronous active-low reset, clock enable
//   tdata_s/tuser_s/tlast_s/tvalid_s/tready_s : magnitude input stream
//   tdata_m/tuser_m/tvalid_m/tready_m         : result stream, tuser_m = frame error
//   frame_err            : one-cycle pulse on any framing violation
module spectrum_peak_finder
    import spectrum_peak_finder_pkg::*;
#(
    parameter int DW        = 16,
    parameter int IW        = 10,
    parameter int FRAME_LEN = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ce,
`ifdef PEAK_THRESHOLD_EN
    input  logic        [DW-1:0] thresh,
`endif
    input  logic signed [DW-1:0] tdata_s,
    input  logic                 tuser_s,
    input  logic                 tlast_s,
    input  logic                 tvalid_s,
    output logic                 tready_s,
    output logic [IW+DW-1:0]     tdata_m,
    output logic                 tuser_m,
    output logic                 tvalid_m,
    input  logic                 tready_m,
    output logic                 frame_err
);

    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_LEN - 1);
    localparam int IDX_LSB = res_idx_lsb(DW);
    localparam int IDX_MSB = res_idx_msb(IW, DW);

    pf_state_e        r_state;
    logic [IW-1:0]    r_index;
    logic [IW+DW-1:0] r_tdata_m;
    logic             r_tuser_m;
    logic             r_tvalid_m;
    logic             r_frame_err;

    logic          w_acc;
    logic          w_load;
    logic          w_in_frame;
    logic [IW-1:0] w_pos;
    logic          w_at_last;
    logic          w_done;
    logic          w_overrun;
    logic          w_err;
    logic          w_pass;
    logic          w_emit;
    logic [DW-1:0] w_next_peak;
    logic [IW-1:0] w_next_idx;

    assign tready_s = ce & ~(r_tvalid_m & ~tready_m);
    assign w_acc    = tvalid_s & tready_s;

    // A tuser beat always (re)starts a frame, whether idle or mid-frame.
    assign w_load     = w_acc & tuser_s;
    assign w_in_frame = w_load | (w_acc & (r_state == ST_ACCUM));
    assign w_pos      = w_load ? '0 : r_index;
    assign w_at_last  = (w_pos == LAST_IDX);
    assign w_done     = w_in_frame & tlast_s;
    // The last legal bin without tlast ends the frame here, so r_index never wraps.
    assign w_overrun  = w_in_frame & ~tlast_s & w_at_last;
    assign w_err      = (w_load & (r_state == ST_ACCUM))
                      | (w_done & ~w_at_last)
                      | w_overrun;

`ifdef PEAK_THRESHOLD_EN
    assign w_pass = (w_next_peak >= thresh);
`else
    assign w_pass = 1'b1;
`endif
    assign w_emit = w_done & w_pass;

    spectrum_peak_finder_peak_cmp #(
        .DW (DW),
        .IW (IW)
    ) u_peak_cmp (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_update    (w_in_frame),
        .i_load      (w_load),
        .i_sample    (tdata_s),
        .i_index     (w_pos),
        .o_next_peak (w_next_peak),
        .o_next_idx  (w_next_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_index     <= '0;
            r_tdata_m   <= '0;
            r_tuser_m   <= 1'b0;
            r_tvalid_m  <= 1'b0;
            r_frame_err <= 1'b0;
        end else if (ce) begin
            r_frame_err <= w_err;

            if (r_tvalid_m && tready_m) begin
                r_tvalid_m <= 1'b0;
            end
            // Acceptance implies the slot is free or draining, so no result is overwritten.
            if (w_emit) begin
                r_tvalid_m                <= 1'b1;
                r_tdata_m[IDX_MSB:IDX_LSB] <= w_next_idx;
                r_tdata_m[DW-1:0]          <= w_next_peak;
                r_tuser_m                 <= ~w_at_last;
            end

            if (w_done || w_overrun) begin
                r_state <= ST_IDLE;
                r_index <= '0;
            end else if (w_in_frame) begin
                r_state <= ST_ACCUM;
                r_index <= w_pos + 1'b1;
            end
        end
    end

    assign tdata_m   = r_tdata_m;
    assign tuser_m   = r_tuser_m;
    assign tvalid_m  = r_tvalid_m;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_spectrum_peak_finder.sv
// tb/tb_spectrum_peak_finder.sv - scoreboard bench for spectrum_peak_finder
module tb_spectrum_peak_finder;

    localparam int DW = 16;
    localparam int IW = 3;
    localparam int FL = 8;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 ce = 1'b1;
    logic signed [DW-1:0] tdata_s = '0;
    logic                 tuser_s = 1'b0;
    logic                 tlast_s = 1'b0;
    logic                 tvalid_s = 1'b0;
    logic                 tready_s;
    logic [IW+DW-1:0]     tdata_m;
    logic                 tuser_m;
    logic                 tvalid_m;
    logic                 tready_m = 1'b1;
    logic                 frame_err;
`ifdef PEAK_THRESHOLD_EN
    logic [DW-1:0]        thresh = '0;
`endif

    spectrum_peak_finder #(.DW(DW), .IW(IW), .FRAME_LEN(FL)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ce        (ce),
`ifdef PEAK_THRESHOLD_EN
        .thresh    (thresh),
`endif
        .tdata_s   (tdata_s),
        .tuser_s   (tuser_s),
        .tlast_s   (tlast_s),
        .tvalid_s  (tvalid_s),
        .tready_s  (tready_s),
        .tdata_m   (tdata_m),
        .tuser_m   (tuser_m),
        .tvalid_m  (tvalid_m),
        .tready_m  (tready_m),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int err_seen = 0;
    int err_exp  = 0;
    logic [IW+DW:0] exp_q[$];   // {tuser, tdata}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [IW+DW:0] mk(input int idx, input int pk, input bit err);
        logic [IW+DW:0] v;
        v = {err, IW'(idx), DW'(pk)};
        return v;
    endfunction

    // Monitor: compare each accepted result beat with the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && ce && frame_err) err_seen++;
        if (reset_n && tvalid_m && tready_m) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", {13'd0, tuser_m, tdata_m}, 32'hFFFF_FFFF);
            end else begin
                logic [IW+DW:0] e;
                e = exp_q.pop_front();
                check("result_beat", {13'd0, tuser_m, tdata_m}, {13'd0, e});
            end
        end
    end

    task automatic send(input int d, input bit u, input bit l);
        int k;
        tdata_s  = DW'(d);
        tuser_s  = u;
        tlast_s  = l;
        tvalid_s = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tready_s) break;
        end
        if (k == 200) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        tvalid_s = 1'b0;
        tuser_s  = 1'b0;
        tlast_s  = 1'b0;
    endtask

    task automatic send_frame(input int s[FL], input int n, input bit with_last);
        for (int i = 0; i < n; i++) send(s[i], i == 0, with_last && (i == n - 1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f[FL];
        logic [IW+DW-1:0] held;

        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("reset_tvalid_m", {31'd0, tvalid_m}, 32'd0);
        check("reset_tdata_m", {13'd0, tdata_m}, 32'd0);
        check("reset_tuser_m", {31'd0, tuser_m}, 32'd0);
        check("reset_frame_err", {31'd0, frame_err}, 32'd0);
        check("reset_tready_s", {31'd0, tready_s}, 32'd1);
        @(posedge clk); #1;

        // Beats without tuser in IDLE are dropped
        send(77, 0, 0);
        send(88, 0, 1);
        idle(2);

        // Basic frame, tie keeps lowest bin, 1-cycle latency
        f = '{5, 9, 3, 9, 1, 0, 2, 4};
        exp_q.push_back(mk(1, 9, 0));
        send_frame(f, 8, 1);
        check("latency_tvalid_m", {31'd0, tvalid_m}, 32'd1);
        idle(2);

        // Negative clamp
        f = '{-300, -300, -300, -300, -300, -300, 7, -300};
        exp_q.push_back(mk(6, 7, 0));
        send_frame(f, 8, 1);
        f = '{-1, -5, -300, -32768, -2, -9, -7, -300};
        exp_q.push_back(mk(0, 0, 0));
        send_frame(f, 8, 1);
        idle(2);

        // Short frame: 5 bins
        f = '{1, 2, 8, 3, 4, 0, 0, 0};
        exp_q.push_back(mk(2, 8, 1));
        err_exp++;
        send_frame(f, 5, 1);
        idle(2);

        // Overrun: eight bins without tlast, then a normal frame
        f = '{1, 2, 3, 4, 5, 6, 7, 8};
        err_exp++;
        send_frame(f, 8, 0);
        f = '{10, 20, 30, 40, 50, 60, 70, 80};
        exp_q.push_back(mk(7, 80, 0));
        send_frame(f, 8, 1);
        idle(2);

        // 1-bin frame
        exp_q.push_back(mk(0, 42, 1));
        err_exp++;
        send(42, 1, 1);
        idle(2);

        // Mid-frame restart
        send(900, 1, 0);
        send(901, 0, 0);
        send(902, 0, 0);
        err_exp++;
        f = '{3, 3, 11, 2, 11, 0, 1, 1};
        exp_q.push_back(mk(2, 11, 0));
        send_frame(f, 8, 1);
        idle(2);

        // ce low freezes everything, even with a tuser beat presented
        f = '{4, 6, 2, 31, 5, 1, 0, 3};
        exp_q.push_back(mk(3, 31, 0));
        send(f[0], 1, 0);
        send(f[1], 0, 0);
        send(f[2], 0, 0);
        ce = 1'b0;
        tdata_s = 16'd500; tuser_s = 1'b1; tvalid_s = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("ce_low_tready_s", {31'd0, tready_s}, 32'd0);
        end
        @(posedge clk); #1;
        tvalid_s = 1'b0; tuser_s = 1'b0; ce = 1'b1;
        for (int i = 3; i < FL; i++) send(f[i], 0, i == FL - 1);
        idle(2);

        // Back-pressure: result held 10 cycles, next frame stalls then resumes
        tready_m = 1'b0;
        f = '{12, 0, 0, 0, 0, 0, 0, 13};
        exp_q.push_back(mk(7, 13, 0));
        send_frame(f, 8, 1);
        held = {3'd7, 16'd13};
        f = '{2, 4, 6, 8, 60, 4, 2, 0};
        exp_q.push_back(mk(4, 60, 0));
        fork
            send_frame(f, 8, 1);
            begin
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check("hold_tvalid_m", {31'd0, tvalid_m}, 32'd1);
                    check("hold_tdata_m", {13'd0, tdata_m}, {13'd0, held});
                    check("hold_tready_s", {31'd0, tready_s}, 32'd0);
                end
                @(posedge clk); #1;
                tready_m = 1'b1;
            end
        join
        idle(3);

`ifdef PEAK_THRESHOLD_EN
        thresh = 16'd100;
        f = '{1, 99, 5, 5, 5, 5, 5, 5};
        send_frame(f, 8, 1);
        f = '{1, 5, 5, 100, 5, 5, 5, 5};
        exp_q.push_back(mk(3, 100, 0));
        send_frame(f, 8, 1);
        idle(3);
`endif

        idle(5);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        check("frame_err_pulses", err_seen, err_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spectrum_peak_finder.md
Name: spectrum_peak_finder

Overview:
- Sits directly downstream of the complex-modulus stage and consumes its magnitude stream: signed DW-bit samples, tuser = first bin of a frame, tlast = last bin.
- Tracks the largest magnitude and its bin index across each frame.
- Emits one {index, peak} result beat per frame on an AXI-stream-style master port, with a frame-error flag.

Parameters:
- DW, 16, magnitude sample width (signed).
- IW, 10, bin index width.
- FRAME_LEN, 1024, expected bins per frame; must satisfy 2 <= FRAME_LEN <= 2**IW.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- ce  in  1  clock enable; all state frozen when low.
- tdata_s  in  DW  signed magnitude sample.
- tuser_s  in  1  start of frame.
- tlast_s  in  1  end of frame.
- tvalid_s  in  1  input valid.
- tready_s  out  1  input ready.
- tdata_m  out  IW+DW  result: [IW+DW-1:DW] = peak bin index, [DW-1:0] = peak magnitude.
- tuser_m  out  1  frame-error flag qualifying the result beat.
- tvalid_m  out  1  result valid.
- tready_m  in  1  result ready.
- frame_err  out  1  one-cycle pulse on any framing violation.

Behaviour:
- Reset values: tdata_m=0, tuser_m=0, tvalid_m=0, frame_err=0; state=IDLE, index=0, peak=0, peak_idx=0.
- Handshake:
  - tready_s = ce & ~(tvalid_m & ~tready_m).
  - A beat is accepted when tvalid_s & tready_s.
  - tvalid_m stays asserted with tdata_m/tuser_m stable until tready_m.
- Magnitude: negative samples are clamped to 0 before comparison.
- Comparison is strictly greater-than, so on a tie the first (lowest index) bin wins.
- States:
  - IDLE: accepted beats without tuser_s are dropped. A beat with tuser_s loads peak=sample, peak_idx=0, index=1, and goes to ACCUM. If that beat also has tlast_s, see the rule for tuser_s and tlast_s together.
  - ACCUM: on each accepted beat, if sample > peak, then peak=sample and peak_idx=index. Then index increments.
- tlast_s on an accepted beat (the comparison for that beat is included):
  - The next cycle: tvalid_m=1, tdata_m={peak_idx, peak}, tuser_m = (index != FRAME_LEN-1).
  - State returns to IDLE.
  - Latency from the tlast beat to tvalid_m is 1 cycle.
- tuser_s mid-frame (ACCUM): the frame restarts on this beat (index 0 load) and frame_err pulses. No result is emitted for the aborted frame.
- Overrun: an accepted beat at index == FRAME_LEN-1 without tlast_s causes frame_err to pulse. The frame is discarded (no result) and the state goes to IDLE.
- tuser_s and tlast_s on the same beat: a 1-bin frame. The result is {0, sample} with tuser_m=1, and frame_err pulses.
- Short frame (tlast_s early): the result is emitted with tuser_m=1, and frame_err pulses.
- Back-to-back frames: the next tuser beat may arrive in the cycle after tlast. It is accepted if the output slot is free; otherwise it stalls via tready_s.
- ce low: tready_s=0, and no state, output or pulse changes. tvalid_m holds its value.
- Reset mid-frame: partial results are lost and the block waits in IDLE for the next tuser_s.
- Width rule: index is IW bits and is never allowed to wrap; the overrun rule fires first.

Optional Feature:
- Macro PEAK_THRESHOLD_EN adds a port `thresh  in  DW` (unsigned compare against the clamped peak).
- With the macro: a completed frame whose peak < thresh produces no result beat (tvalid_m stays 0). Framing errors still pulse frame_err.
- Without the macro: every completed frame emits a result.

Decomposition:
- Shared header dsp_defs.vh holds the state encodings (IDLE, ACCUM) and the result-field offset macros (index field MSB/LSB), for reuse by downstream consumers.
- One natural sub-module, peak_cmp: clamp, strict compare, and peak/peak_idx register update, with a load (restart) input.

Test Plan (bench with DW=16, IW=3, FRAME_LEN=8):
- Frame 5,9,3,9,1,0,2,4 with tuser on the first bin and tlast on the eighth, tready_m=1 -> one cycle after tlast: tdata_m={3'd1,16'd9}, tuser_m=0, frame_err never asserted.
- Samples -300 on all bins except bin 6 = 7 -> result {6,7}. An all-negative frame -> {0,0}.
- tlast on bin 4 (5 bins) -> result emitted with tuser_m=1, and frame_err pulses 1 cycle.
- Eight bins without tlast, then a tuser beat -> frame_err pulses at bin 7 and no result. The new frame then proceeds normally.
- tready_m=0 for 10 cycles after a result -> tvalid_m and tdata_m are held, and tready_s=0. On release, the second frame's beats resume with no sample lost.
- With PEAK_THRESHOLD_EN and thresh=100: frame peak 99 -> no tvalid_m; frame peak 100 -> result emitted.
